// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
//
// The h/v counters advance one pixel on each clk edge where pix_ce is high.
// Every output is registered and decoded from the position the counters move
// to on that same edge, so all outputs describe the current position with no
// extra latency and stay aligned with one another.
//
// Optional prefetch: define VGA_TIMING_PREFETCH_EN. fetch_* then decode the
// position one pixel period ahead of the current position. Without the macro,
// fetch_* are tied to 0 and no prefetch logic is built.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   pix_ce       pixel clock enable; one pixel per clk while high
//   hsync/vsync  sync pulses, active level set by HSYNC_POL/VSYNC_POL
//   video_on     current position is inside the active area
//   pixel_x/y    active column/row, 0 outside the active columns/rows
//   line_start   current position has h == 0
//   frame_start  current position is (0,0)
//   fetch_x/y    prefetch column/row (one pixel ahead)
//   fetch_valid  prefetch position is inside the active area
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [CNT_W-1:0] fetch_x,
  output logic [CNT_W-1:0] fetch_y,
  output logic             fetch_valid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  // Sync windows are stored as inclusive first/last so that a window ending
  // exactly at 2^CNT_W does not truncate to zero.
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  logic [CNT_W-1:0] h, v;
  logic [CNT_W-1:0] h_nxt, v_nxt;

  // Next raster position after (hh,vv); v moves only when h wraps.
  function automatic logic [2*CNT_W-1:0] next_pos(input logic [CNT_W-1:0] hh,
                                                  input logic [CNT_W-1:0] vv);
    logic [CNT_W-1:0] hn, vn;
    if (hh == H_LAST) begin
      hn = '0;
      vn = (vv == V_LAST) ? '0 : vv + CNT_W'(1);
    end else begin
      hn = hh + CNT_W'(1);
      vn = vv;
    end
    return {hn, vn};
  endfunction

  always_comb begin
    {h_nxt, v_nxt} = next_pos(h, v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= H_LAST;
      v           <= V_LAST;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      h           <= h_nxt;
      v           <= v_nxt;
      hsync       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? HS_ON : ~HS_ON;
      vsync       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? VS_ON : ~VS_ON;
      video_on    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      pixel_x     <= (h_nxt < H_ACT) ? h_nxt : '0;
      pixel_y     <= (v_nxt < V_ACT) ? v_nxt : '0;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0] fh, fv;

  always_comb begin
    {fh, fv} = next_pos(h_nxt, v_nxt);
  end

  // Updated only on pix_ce so that, out of reset, fetch_* stay 0 until the
  // first pixel rather than showing the lookahead of the reset position.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_x     <= '0;
      fetch_y     <= '0;
      fetch_valid <= 1'b0;
    end else if (pix_ce) begin
      fetch_x     <= (fh < H_ACT) ? fh : '0;
      fetch_y     <= (fv < V_ACT) ? fv : '0;
      fetch_valid <= (fh < H_ACT) && (fv < V_ACT);
    end
  end
`else
  assign fetch_x     = '0;
  assign fetch_y     = '0;
  assign fetch_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk;
  logic rst_a, ce_a, rst_b, ce_b;

  // default 640x480 instance
  logic       hs_a, vs_a, von_a, ls_a, fs_a, fval_a;
  logic [9:0] px_a, py_a, fx_a, fy_a;
  // small 8x6 instance, high-active syncs
  logic       hs_b, vs_b, von_b, ls_b, fs_b, fval_b;
  logic [3:0] px_b, py_b, fx_b, fy_b;

  int total = 0;
  int bad   = 0;
  int eh, ev;   // model position of instance a
  int sh, sv;   // model position of instance b

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_ce(ce_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .pixel_x(px_a), .pixel_y(py_a),
    .line_start(ls_a), .frame_start(fs_a),
    .fetch_x(fx_a), .fetch_y(fy_a), .fetch_valid(fval_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_ce(ce_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .pixel_x(px_b), .pixel_y(py_b),
    .line_start(ls_b), .frame_start(fs_b),
    .fetch_x(fx_b), .fetch_y(fy_b), .fetch_valid(fval_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_a();
    if (eh == 799) begin
      eh = 0;
      ev = (ev == 524) ? 0 : ev + 1;
    end else eh++;
  endtask

  task automatic adv_b();
    if (sh == 7) begin
      sh = 0;
      sv = (sv == 5) ? 0 : sv + 1;
    end else sh++;
  endtask

  task automatic chk_rst_a();
    check("a_rst_hsync", hs_a, 1);
    check("a_rst_vsync", vs_a, 1);
    check("a_rst_von", von_a, 0);
    check("a_rst_px", px_a, 0);
    check("a_rst_py", py_a, 0);
    check("a_rst_ls", ls_a, 0);
    check("a_rst_fs", fs_a, 0);
    check("a_rst_fx", fx_a, 0);
    check("a_rst_fy", fy_a, 0);
    check("a_rst_fval", fval_a, 0);
  endtask

  // Default mode: active 0..639, hsync low 656..751; lines 0..479, vsync low 490..491.
  task automatic chk_a();
    int nh, nv;
    check("a_von", von_a, (eh < 640 && ev < 480) ? 1 : 0);
    check("a_px", px_a, (eh < 640) ? eh : 0);
    check("a_py", py_a, (ev < 480) ? ev : 0);
    check("a_hsync", hs_a, (eh >= 656 && eh <= 751) ? 0 : 1);
    check("a_vsync", vs_a, (ev >= 490 && ev <= 491) ? 0 : 1);
    check("a_ls", ls_a, (eh == 0) ? 1 : 0);
    check("a_fs", fs_a, (eh == 0 && ev == 0) ? 1 : 0);
    nh = (eh == 799) ? 0 : eh + 1;
    nv = (eh == 799) ? ((ev == 524) ? 0 : ev + 1) : ev;
`ifdef VGA_TIMING_PREFETCH_EN
    check("a_fx", fx_a, (nh < 640) ? nh : 0);
    check("a_fy", fy_a, (nv < 480) ? nv : 0);
    check("a_fval", fval_a, (nh < 640 && nv < 480) ? 1 : 0);
`else
    check("a_fx_off", fx_a, 0);
    check("a_fy_off", fy_a, 0);
    check("a_fval_off", fval_a, 0);
`endif
  endtask

  // Small mode: active 0..3 x 0..2, hsync high at h 5..6, vsync high on line 4.
  task automatic chk_b();
    int nh, nv;
    check("b_von", von_b, (sh < 4 && sv < 3) ? 1 : 0);
    check("b_px", px_b, (sh < 4) ? sh : 0);
    check("b_py", py_b, (sv < 3) ? sv : 0);
    check("b_hsync", hs_b, (sh == 5 || sh == 6) ? 1 : 0);
    check("b_vsync", vs_b, (sv == 4) ? 1 : 0);
    check("b_ls", ls_b, (sh == 0) ? 1 : 0);
    check("b_fs", fs_b, (sh == 0 && sv == 0) ? 1 : 0);
    nh = (sh == 7) ? 0 : sh + 1;
    nv = (sh == 7) ? ((sv == 5) ? 0 : sv + 1) : sv;
`ifdef VGA_TIMING_PREFETCH_EN
    check("b_fx", fx_b, (nh < 4) ? nh : 0);
    check("b_fy", fy_b, (nv < 3) ? nv : 0);
    check("b_fval", fval_b, (nh < 4 && nv < 3) ? 1 : 0);
`else
    check("b_fx_off", fx_b, 0);
    check("b_fy_off", fy_b, 0);
    check("b_fval_off", fval_b, 0);
`endif
  endtask

  initial begin
    int hs_low, hs_first, last_fs, cyc;
    logic [9:0] hold_px;
    logic       hold_hs, hold_von, hold_fs, hold_ls;

    rst_a = 1'b1; ce_a = 1'b1; rst_b = 1'b1; ce_b = 1'b1;
    repeat (3) step();
    chk_rst_a();
    check("b_rst_hsync", hs_b, 0);
    check("b_rst_vsync", vs_b, 0);
    check("b_rst_fs", fs_b, 0);

    // first pixel lands on (0,0)
    rst_a = 1'b0;
    step();
    eh = 0; ev = 0;
    check("a_first_fs", fs_a, 1);
    check("a_first_ls", ls_a, 1);
    check("a_first_von", von_a, 1);
    chk_a();
    step();
    adv_a();
    check("a_second_px", px_a, 1);
    check("a_second_fs", fs_a, 0);
    chk_a();

    // rest of line 0 and start of line 1
    hs_low = 0; hs_first = -1;
    for (int i = 0; i < 820; i++) begin
      step();
      adv_a();
      chk_a();
      if (ev == 0 && hs_a == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = eh;
      end
      if (ev == 0 && eh == 639) check("a_px_639", px_a, 639);
      if (ev == 0 && eh == 640) begin
        check("a_von_drop", von_a, 0);
        check("a_px_drop", px_a, 0);
      end
      if (ev == 1 && eh == 0) check("a_line1_ls", ls_a, 1);
    end
    check("a_hsync_width", hs_low, 96);
    check("a_hsync_first", hs_first, 656);

    // pix_ce every other clk: outputs hold on ce=0
    for (int i = 0; i < 30; i++) begin
      hold_px = px_a; hold_hs = hs_a; hold_von = von_a;
      hold_fs = fs_a; hold_ls = ls_a;
      ce_a = 1'b0;
      step();
      check("a_hold_px", px_a, hold_px);
      check("a_hold_hs", hs_a, hold_hs);
      check("a_hold_von", von_a, hold_von);
      check("a_hold_fs", fs_a, hold_fs);
      check("a_hold_ls", ls_a, hold_ls);
      ce_a = 1'b1;
      step();
      adv_a();
      chk_a();
    end

    // reset mid-line at h=300 on the same edge as pix_ce
    while (eh != 300) begin
      step();
      adv_a();
    end
    chk_a();
    rst_a = 1'b1; ce_a = 1'b1;
    step();
    chk_rst_a();
    rst_a = 1'b0; ce_a = 1'b0;
    step();
    chk_rst_a();
    ce_a = 1'b1;
    step();
    eh = 0; ev = 0;
    check("a_rst_then_fs", fs_a, 1);
    chk_a();
    rst_a = 1'b1;

    // small mode: two full frames plus a bit
    rst_b = 1'b0; ce_b = 1'b1;
    sh = 7; sv = 5;
    last_fs = -1; cyc = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      cyc++;
      adv_b();
      chk_b();
      if (fs_b) begin
        if (last_fs >= 0) check("b_frame_period", cyc - last_fs, 48);
        last_fs = cyc;
      end
      if (sh == 7 && sv == 5) begin
`ifdef VGA_TIMING_PREFETCH_EN
        check("b_wrap_fval", fval_b, 1);
        check("b_wrap_fx", fx_b, 0);
        check("b_wrap_fy", fy_b, 0);
`endif
        check("b_wrap_von", von_b, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
